muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide responder for the MIPS datapath. It takes operands from the execute stage, which holds on the request until accepted, and returns a {HI, LO} result pair. It serves the slow operations (MULT, MULTU, DIV, DIVU) that the combinational ALU does not handle well. It has a valid/ready request port, a valid/ready result port and a flush input for exception cancellation.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit returning {HI, LO}; WIDTH cycles per op.
// Optional FAST_MUL_EN: single-step native multiply for MULT/MULTU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rawa_q, rawa_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step;
  logic [2*WIDTH-1:0] mul_raw, mul_res;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
  logic               is_signed, neg, last;

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign res_hi    = hi_q;
  assign res_lo    = lo_q;

  assign a_abs = (!req_op[0] && req_a[WIDTH-1]) ? -req_a : req_a;
  assign b_abs = (!req_op[0] && req_b[WIDTH-1]) ? -req_b : req_b;

  assign is_signed = !op_q[0];
  assign neg       = sa_q ^ sb_q;

`ifdef FAST_MUL_EN
  assign mul_raw = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]}
                 * {{WIDTH{1'b0}}, b_q};
  assign last    = (cnt_q == CW'(WIDTH-1)) || !op_q[1];
`else
  assign mul_raw = step;
  assign last    = (cnt_q == CW'(WIDTH-1));
`endif

  // One shift-add or restoring-divide iteration, plus sign fix-up
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    mul_nx = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                      : {1'b0, acc_q[2*WIDTH-1:1]};
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    div_nx = diff[WIDTH]
           ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
           : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step   = op_q[1] ? div_nx : mul_nx;
    mul_res = (is_signed && neg) ? -mul_raw : mul_raw;
    quo = step[WIDTH-1:0];
    rem = step[2*WIDTH-1:WIDTH];
    if (is_signed && neg) quo = -quo;
    if (is_signed && sa_q) rem = -rem;
    // Divide by zero bypasses sign correction entirely
    if (b_q == '0) begin
      quo = '1;
      rem = rawa_q;
    end
  end

  // Next-state: flush dominates accept and result handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    b_d     = b_q;
    rawa_d  = rawa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          op_d    = req_op;
          sa_d    = req_a[WIDTH-1];
          sb_d    = req_b[WIDTH-1];
          acc_d   = {{WIDTH{1'b0}}, a_abs};
          b_d     = b_abs;
          rawa_d  = req_a;
          cnt_d   = '0;
          state_d = S_CALC;
        end
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = S_DONE;
            if (op_q[1]) begin
              hi_d = rem;
              lo_d = quo;
            end else begin
              hi_d = mul_res[2*WIDTH-1:WIDTH];
              lo_d = mul_res[WIDTH-1:0];
            end
          end
        end
        S_DONE: if (res_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      rawa_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      rawa_q  <= rawa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan steps plus
// random ops against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         flush = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_hi, res_lo;
  logic         busy;

  int compared = 0;
  int mism = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint pa, pb;
    int qa, qb;
    case (op)
      2'b00: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef FAST_MUL_EN
    return op[1] ? W : 1;
`else
    return (op == 2'b00) ? W : W;
`endif
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [63:0] got, output int lat);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {res_hi, res_lo};
  endtask

  task automatic release_res();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    logic [63:0] got;
    int lat;
    do_op(op, a, b, got, lat);
    check({tag, " result"}, got, exp);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(op)));
    check({tag, " ready in DONE"}, {63'd0, req_ready}, 64'd0);
    release_res();
    check({tag, " idle after take"},
          {62'd0, req_ready, res_valid}, 64'd2);
  endtask

  initial begin : main
    logic [63:0] got, held;
    logic [1:0]  op;
    logic [31:0] a, b;
    int lat;
    bit seen;

    repeat (2) @(negedge clk);
    check("reset outputs",
          {59'd0, req_ready, res_valid, busy, |res_hi, |res_lo},
          64'h10);
    resetn = 1'b1;
    @(negedge clk);
    check("post-reset outputs",
          {61'd0, req_ready, res_valid, busy}, 64'h4);

    run_op("MULT -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5,
           64'hFFFF_FFFF_FFFF_FFF1);
    run_op("MULTU ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001);
    run_op("MULT ff*ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'h0000_0000_0000_0001);
    run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
           64'hFFFF_FFFF_FFFF_FFFD);
    run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7,
           64'h0000_0002_0000_000E);
    run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000);
    run_op("DIVU 100/0", 2'b11, 32'h64, 32'd0,
           64'h0000_0064_FFFF_FFFF);
    run_op("DIV -100/0", 2'b10, 32'hFFFF_FF9C, 32'd0,
           64'hFFFF_FF9C_FFFF_FFFF);
    run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE,
           64'h0000_0001_FFFF_FFFD);

    // Result held while consumer stalls
    do_op(2'b01, 32'd1234, 32'd5678, held, lat);
    check("hold result", held, 64'(1234 * 5678));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid/ready/busy",
            {61'd0, res_valid, req_ready, busy}, 64'h5);
      check("hold data", {res_hi, res_lo}, held);
    end
    release_res();
    check("hold release idle",
          {61'd0, req_ready, res_valid, busy}, 64'h4);

    // Flush mid-CALC
    @(negedge clk);
    req_op = 2'b11; req_a = 32'd999; req_b = 32'd10;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush to idle",
          {61'd0, req_ready, res_valid, busy}, 64'h4);
    check("flush keeps data", {res_hi, res_lo}, held);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= res_valid;
    end
    check("no valid after flush", {63'd0, seen}, 64'd0);
    run_op("after flush", 2'b11, 32'd999, 32'd10,
           {32'd9, 32'd99});

    // Flush beats accept in IDLE
    @(negedge clk);
    req_op = 2'b00; req_a = 32'd3; req_b = 32'd3;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush blocks accept", {63'd0, busy}, 64'd0);

    // Flush in DONE drops the result but keeps data regs
    do_op(2'b10, 32'hFFFF_FF00, 32'd16, got, lat);
    check("pre-flush result", got, model(2'b10, 32'hFFFF_FF00, 32'd16));
    @(negedge clk); flush = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; res_ready = 1'b0;
    check("flush in DONE",
          {61'd0, req_ready, res_valid, busy}, 64'h4);
    check("flush DONE keeps data", {res_hi, res_lo}, got);

    // Async reset mid-CALC
    @(negedge clk);
    req_op = 2'b00; req_a = 32'd77; req_b = 32'd88;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2; resetn = 1'b0;
    #1;
    check("async reset ctrl",
          {61'd0, req_ready, res_valid, busy}, 64'h4);
    check("async reset data", {res_hi, res_lo}, 64'd0);
    @(negedge clk); resetn = 1'b1;
    run_op("after reset", 2'b00, 32'd77, 32'd88, 64'd6776);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b,
             model(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
